// File: rtl/wb_axi_write_ctrl_if.sv
// rtl/wb_axi_write_ctrl_if.sv - AXI write-channel bundle (AW, W, B) between write controller and slave
interface wb_axi_write_ctrl_if;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      output wdata, wstrb, wlast, wvalid, bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      input  wdata, wstrb, wlast, wvalid, bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/wb_axi_write_ctrl.sv
// rtl/wb_axi_write_ctrl.sv - drains the write buffer as 8-beat INCR AXI bursts with error and timeout status
module wb_axi_write_ctrl #(
   parameter logic [3:0]  AXI_ID  = 4'd1,
   parameter logic [15:0] TIMEOUT = 16'd1023
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [31:0]          pointer,
   input  logic [31:0]          buf_addr,
   input  logic [31:0]          buf_data,
   input  logic                 buf_last,
   output logic [3:0]           crt_pull,
   output logic [3:0]           nxt_pull,
   input  logic                 hold,
   wb_axi_write_ctrl_if.master  axi,
   output logic                 wb_idle,
   output logic                 err_bresp,
   output logic                 err_last,
   output logic                 err_timeout,
   output logic [31:0]          burst_cnt
);

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      PULL   = 4'd4,
      SEND_0 = 4'd5,
      SEND_1 = 4'd6,
      SEND_2 = 4'd7,
      SEND_3 = 4'd8,
      SEND_4 = 4'd9,
      SEND_5 = 4'd10,
      SEND_6 = 4'd11,
      SEND_7 = 4'd12,
      WAIT_B = 4'd13
   } state_t;

   state_t      state;
   state_t      nxt;
   logic [15:0] wait_cnt;
   logic [15:0] wait_nxt;
   logic        nxt_send;
   logic        w_hs;
   logic        b_hs;

   assign axi.awid    = AXI_ID;
   assign axi.awlen   = 8'd7;
   assign axi.awsize  = 3'b010;
   assign axi.awburst = 2'b01;
   assign axi.wstrb   = 4'hF;

   assign crt_pull = state;
   assign nxt_pull = nxt;
   assign wb_idle  = (state == IDLE) && (pointer == 32'd0);
   assign nxt_send = (nxt >= SEND_0) && (nxt <= SEND_7);
   assign w_hs     = axi.wvalid && axi.wready;
   assign b_hs     = axi.bvalid && axi.bready;
   assign wait_nxt = wait_cnt + 16'd1;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (pointer != 32'd0 && !hold) nxt = PULL;
         PULL:    if (axi.awready) nxt = SEND_0;
         SEND_0, SEND_1, SEND_2, SEND_3,
         SEND_4, SEND_5, SEND_6:
                  if (axi.wready) nxt = state_t'(state + 4'd1);
         SEND_7:  if (axi.wready) nxt = WAIT_B;
         WAIT_B:  if (axi.bvalid) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state; address and data are captured
   // on entry to their state and held while the slave stalls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         wait_cnt    <= 16'd0;
         axi.awvalid <= 1'b0;
         axi.awaddr  <= 32'd0;
         axi.wvalid  <= 1'b0;
         axi.wdata   <= 32'd0;
         axi.wlast   <= 1'b0;
         axi.bready  <= 1'b0;
         err_bresp   <= 1'b0;
         err_last    <= 1'b0;
         err_timeout <= 1'b0;
         burst_cnt   <= 32'd0;
      end else begin
         state       <= nxt;
         axi.awvalid <= (nxt == PULL);
         axi.awaddr  <= (nxt != PULL) ? 32'd0 : (state == PULL) ? axi.awaddr : buf_addr;
         axi.wvalid  <= nxt_send;
         axi.wdata   <= !nxt_send ? 32'd0 : (nxt == state) ? axi.wdata : buf_data;
         axi.wlast   <= (nxt == SEND_7);
         axi.bready  <= (nxt == WAIT_B);

         // Timeout only flags the stall; the burst keeps waiting for its handshake.
         if (nxt != state)
            wait_cnt <= 16'd0;
         else if (state != IDLE && wait_cnt != TIMEOUT)
            wait_cnt <= wait_nxt;
         if (state != IDLE && nxt == state && wait_nxt == TIMEOUT)
            err_timeout <= 1'b1;

         if (b_hs && axi.bresp != 2'b00)
            err_bresp <= 1'b1;
         if (w_hs && (buf_last != axi.wlast))
            err_last <= 1'b1;
         if (b_hs)
            burst_cnt <= burst_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_wb_axi_write_ctrl.sv
// tb/tb_wb_axi_write_ctrl.sv - table-driven and directed bench for wb_axi_write_ctrl
module tb_wb_axi_write_ctrl;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] pointer = 32'd0;
   logic        hold = 1'b0;
   logic        bad_last = 1'b0;
   logic [31:0] buf_addr;
   logic [31:0] buf_data;
   logic        buf_last;
   logic [3:0]  crt_pull;
   logic [3:0]  nxt_pull;
   logic        wb_idle;
   logic        err_bresp;
   logic        err_last;
   logic        err_timeout;
   logic [31:0] burst_cnt;
   logic        junk;

   int tests = 0;
   int fails = 0;

   wb_axi_write_ctrl_if axi ();

   wb_axi_write_ctrl #(.AXI_ID(4'd1), .TIMEOUT(16'd8)) dut (
      .clk(clk), .rstn(rstn), .pointer(pointer), .buf_addr(buf_addr),
      .buf_data(buf_data), .buf_last(buf_last), .crt_pull(crt_pull),
      .nxt_pull(nxt_pull), .hold(hold), .axi(axi), .wb_idle(wb_idle),
      .err_bresp(err_bresp), .err_last(err_last), .err_timeout(err_timeout),
      .burst_cnt(burst_cnt)
   );

   always #5 clk = ~clk;

   // Buffer model: presents beat data for the upcoming state and junk while stalled.
   assign junk     = (crt_pull == nxt_pull) && (crt_pull != 4'd0);
   assign buf_addr = 32'h1C00_0040 ^ (junk ? 32'h0000_FF00 : 32'd0);
   assign buf_data = 32'hD000_0000 | {28'd0, nxt_pull} | (junk ? 32'h00FF_0000 : 32'd0);
   assign buf_last = (crt_pull == 4'd12) ^ bad_last;

   typedef struct {
      logic [3:0] inp;   // {pointer!=0, awready, wready, bvalid}
      logic [3:0] st;
      logic [3:0] vld;   // {awvalid, wvalid, wlast, bready}
      logic [7:0] bcnt;
   } vec_t;

   vec_t tv [0:28];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic do_reset;
      tick;
      rstn = 1'b0;
      pointer = 32'd0; hold = 1'b0; bad_last = 1'b0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      tick;
      rstn = 1'b1;
   endtask

   task automatic run_burst(input logic [1:0] resp);
      int n;
      tick;
      pointer = 32'd1; axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = resp;
      tick;
      pointer = 32'd0;
      n = 0;
      while (crt_pull != 4'd0 && n < 30) begin
         tick;
         n++;
      end
      chk("burst_done", 32'(n < 30), 32'd1);
   endtask

   initial begin
      int n, bursts, idle_run;
      logic gap_ok;
      logic [3:0] prev, cur;
      logic [31:0] exp_addr, exp_data;

      tv[0]  = '{4'b1111, 4'd0,  4'b0000, 8'd0};
      tv[1]  = '{4'b0111, 4'd4,  4'b1000, 8'd0};
      tv[2]  = '{4'b0111, 4'd5,  4'b0100, 8'd0};
      tv[3]  = '{4'b0111, 4'd6,  4'b0100, 8'd0};
      tv[4]  = '{4'b0111, 4'd7,  4'b0100, 8'd0};
      tv[5]  = '{4'b0111, 4'd8,  4'b0100, 8'd0};
      tv[6]  = '{4'b0111, 4'd9,  4'b0100, 8'd0};
      tv[7]  = '{4'b0111, 4'd10, 4'b0100, 8'd0};
      tv[8]  = '{4'b0111, 4'd11, 4'b0100, 8'd0};
      tv[9]  = '{4'b0111, 4'd12, 4'b0110, 8'd0};
      tv[10] = '{4'b0111, 4'd13, 4'b0001, 8'd0};
      tv[11] = '{4'b0111, 4'd0,  4'b0000, 8'd1};
      tv[12] = '{4'b1000, 4'd0,  4'b0000, 8'd1};
      tv[13] = '{4'b0000, 4'd4,  4'b1000, 8'd1};
      tv[14] = '{4'b0000, 4'd4,  4'b1000, 8'd1};
      tv[15] = '{4'b0000, 4'd4,  4'b1000, 8'd1};
      tv[16] = '{4'b0100, 4'd4,  4'b1000, 8'd1};
      tv[17] = '{4'b0011, 4'd5,  4'b0100, 8'd1};
      tv[18] = '{4'b0011, 4'd6,  4'b0100, 8'd1};
      tv[19] = '{4'b0001, 4'd7,  4'b0100, 8'd1};
      tv[20] = '{4'b0001, 4'd7,  4'b0100, 8'd1};
      tv[21] = '{4'b0011, 4'd7,  4'b0100, 8'd1};
      tv[22] = '{4'b0011, 4'd8,  4'b0100, 8'd1};
      tv[23] = '{4'b0011, 4'd9,  4'b0100, 8'd1};
      tv[24] = '{4'b0011, 4'd10, 4'b0100, 8'd1};
      tv[25] = '{4'b0011, 4'd11, 4'b0100, 8'd1};
      tv[26] = '{4'b0011, 4'd12, 4'b0110, 8'd1};
      tv[27] = '{4'b0011, 4'd13, 4'b0001, 8'd1};
      tv[28] = '{4'b0011, 4'd0,  4'b0000, 8'd2};

      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
      #2;
      chk("rst_state", 32'(crt_pull), 32'd0);
      chk("rst_nxt", 32'(nxt_pull), 32'd0);
      chk("rst_valids", 32'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready}), 32'd0);
      chk("rst_addr_data", axi.awaddr | axi.wdata, 32'd0);
      chk("rst_errs", 32'({err_bresp, err_last, err_timeout}), 32'd0);
      chk("rst_bcnt", burst_cnt, 32'd0);
      chk("rst_idle", 32'(wb_idle), 32'd1);
      chk("const_fields", {axi.awid, axi.awlen, 5'd0, axi.awsize, 6'd0, axi.awburst, axi.wstrb},
          {4'd1, 8'd7, 5'd0, 3'b010, 6'd0, 2'b01, 4'hF});
      tick;
      rstn = 1'b1;

      // Scenario 1 (rows 0-11) and stalled scenario 2 (rows 12-28)
      for (int i = 0; i < 29; i++) begin
         tick;
         pointer     = {31'd0, tv[i].inp[3]};
         axi.awready = tv[i].inp[2];
         axi.wready  = tv[i].inp[1];
         axi.bvalid  = tv[i].inp[0];
         axi.bresp   = 2'b00;
         exp_addr = tv[i].vld[3] ? 32'h1C00_0040 : 32'd0;
         exp_data = tv[i].vld[2] ? (32'hD000_0000 | {28'd0, tv[i].st}) : 32'd0;
         chk($sformatf("v%0d_state", i), 32'(crt_pull), 32'(tv[i].st));
         chk($sformatf("v%0d_valids", i), 32'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready}), 32'(tv[i].vld));
         chk($sformatf("v%0d_awaddr", i), axi.awaddr, exp_addr);
         chk($sformatf("v%0d_wdata", i), axi.wdata, exp_data);
         chk($sformatf("v%0d_bcnt", i), burst_cnt, 32'(tv[i].bcnt));
         chk($sformatf("v%0d_excl", i), 32'((32'(axi.awvalid) + 32'(axi.wvalid) + 32'(axi.bready)) <= 32'd1), 32'd1);
      end
      chk("s2_no_errs", 32'({err_bresp, err_last, err_timeout}), 32'd0);

      // Error response still completes the burst
      run_burst(2'b10);
      chk("bresp_err", 32'(err_bresp), 32'd1);
      chk("bresp_state", 32'(crt_pull), 32'd0);
      chk("bresp_bcnt", burst_cnt, 32'd3);
      chk("bresp_no_last_err", 32'(err_last), 32'd0);

      do_reset;
      chk("rst_clears_bresp", 32'(err_bresp), 32'd0);
      bad_last = 1'b1;
      run_burst(2'b00);
      chk("last_err", 32'(err_last), 32'd1);
      chk("last_no_bresp", 32'(err_bresp), 32'd0);

      // Hold blocks start; then three back-to-back bursts
      do_reset;
      tick;
      hold = 1'b1; pointer = 32'd3;
      axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1; axi.bresp = 2'b00;
      repeat (4) tick;
      chk("hold_state", 32'(crt_pull), 32'd0);
      chk("hold_wb_idle", 32'(wb_idle), 32'd0);
      hold = 1'b0;
      bursts = 0; idle_run = 0; gap_ok = 1'b1; n = 0; prev = crt_pull;
      while (bursts < 3 && n < 100) begin
         tick;
         n++;
         cur = crt_pull;
         if (prev == 4'd13 && cur == 4'd0) begin
            bursts++;
            pointer = pointer - 32'd1;
         end
         if (cur == 4'd0) idle_run++;
         else begin
            if (prev == 4'd0 && bursts > 0 && idle_run != 1) gap_ok = 1'b0;
            idle_run = 0;
         end
         prev = cur;
      end
      chk("b2b_bursts", 32'(bursts), 32'd3);
      repeat (2) tick;
      chk("b2b_gap", 32'(gap_ok), 32'd1);
      chk("b2b_bcnt", burst_cnt, 32'd3);
      chk("b2b_idle", 32'(wb_idle), 32'd1);
      chk("b2b_state", 32'(crt_pull), 32'd0);

      // Hold raised mid-burst: burst completes, next start is blocked
      pointer = 32'd1;
      tick;
      chk("hold_mid_pull", 32'(crt_pull), 32'd4);
      hold = 1'b1;
      n = 0;
      while (crt_pull != 4'd0 && n < 30) begin
         tick;
         n++;
      end
      repeat (3) tick;
      chk("hold_mid_state", 32'(crt_pull), 32'd0);
      chk("hold_mid_bcnt", burst_cnt, 32'd4);
      chk("hold_mid_idle", 32'(wb_idle), 32'd0);

      // Timeout with awready stuck low (TIMEOUT=8)
      do_reset;
      pointer = 32'd1;
      tick;
      pointer = 32'd0;
      chk("to_in_pull", 32'(crt_pull), 32'd4);
      repeat (7) tick;
      chk("to_not_yet", 32'(err_timeout), 32'd0);
      tick;
      chk("to_flag", 32'(err_timeout), 32'd1);
      chk("to_awvalid", 32'(axi.awvalid), 32'd1);
      chk("to_state", 32'(crt_pull), 32'd4);
      chk("to_awaddr", axi.awaddr, 32'h1C00_0040);

      // Reset in SEND_4 drops valids at once
      do_reset;
      pointer = 32'd1; axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1;
      tick;
      pointer = 32'd0;
      n = 0;
      while (crt_pull != 4'd9 && n < 20) begin
         tick;
         n++;
      end
      chk("reach_send4", 32'(crt_pull), 32'd9);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valids", 32'({axi.awvalid, axi.wvalid, axi.wlast, axi.bready}), 32'd0);
      chk("mid_rst_state", 32'(crt_pull), 32'd0);
      chk("mid_rst_wdata", axi.wdata, 32'd0);
      tick;
      rstn = 1'b1;
      repeat (4) tick;
      chk("post_rst_state", 32'(crt_pull), 32'd0);
      chk("post_rst_idle", 32'(wb_idle), 32'd1);
      rstn = 1'b0;
      tick;
      rstn = 1'b1;
      pointer = 32'd1;
      tick;
      chk("first_cycle_start", 32'(crt_pull), 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
